// File: rtl/i2s_rx_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : i2s_rx_pkg
//  Description : Shared types, constants and helpers for the I2S receive
//                deserializer. Holds the FSM state encoding, the datapath
//                word width, the default output-buffer depth and the
//                serial shift / word-mask helper functions.
//  Revision    : 1.0 - initial release
// ============================================================================
package i2s_rx_pkg;

    localparam int WORD_W         = 32;
    localparam int OBUF_DEPTH_DEF = 2;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WAIT_WS = 2'd1,
        ST_RUNNING = 2'd2,
        ST_SKIP    = 2'd3
    } state_t;

    // Ones in [wlen:0], zeros above.
    function automatic logic [WORD_W-1:0] word_mask(input logic [4:0] wlen);
        return {WORD_W{1'b1}} >> (5'd31 - wlen);
    endfunction

    // One serial bit into the shift register. LSB-first words enter at the
    // top of the configured word and drift down, so after wlen+1 bits the
    // first bit received sits at index 0.
    function automatic logic [WORD_W-1:0] shift_in(input logic [WORD_W-1:0] sr,
                                                   input logic              b,
                                                   input logic              lsb_first,
                                                   input logic [4:0]        wlen);
        logic [WORD_W-1:0] v;
        if (lsb_first) begin
            v       = sr >> 1;
            v[wlen] = b;
        end else begin
            v = {sr[WORD_W-2:0], b};
        end
        return v;
    endfunction

endpackage
`default_nettype wire

// File: rtl/i2s_rx_obuf.sv
`default_nettype none
// ============================================================================
//  Module      : i2s_rx_obuf
//  Description : Small FIFO-ordered output stage. Accepts up to two words
//                per cycle (word 0 ahead of word 1) and releases one per
//                cycle over a valid/ready handshake. Words that do not fit
//                after the same-cycle pop are dropped (word 1 first) and a
//                one-cycle error pulse is raised; stored words are never
//                overwritten. Flush empties the stage.
//  Ports       : i_clk, i_rstn (sync, active-low), i_flush,
//                i_push_cnt / i_push_data0 / i_push_data1 (push side),
//                o_data / o_valid / i_ready (pop side), o_err (overflow).
//  Revision    : 1.0 - initial release
// ============================================================================
module i2s_rx_obuf #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 32
) (
    input  logic             i_clk,
    input  logic             i_rstn,
    input  logic             i_flush,
    input  logic [1:0]       i_push_cnt,
    input  logic [WIDTH-1:0] i_push_data0,
    input  logic [WIDTH-1:0] i_push_data1,
    output logic [WIDTH-1:0] o_data,
    output logic             o_valid,
    input  logic             i_ready,
    output logic             o_err
);

    localparam int c_CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0]   r_data [DEPTH];
    logic [c_CNT_W-1:0] r_count;
    logic               r_err;

    logic [WIDTH-1:0]   w_data_nxt [DEPTH];
    logic [c_CNT_W-1:0] w_count_nxt;
    logic [c_CNT_W-1:0] w_count_pop;
    logic [c_CNT_W-1:0] w_free;
    logic [c_CNT_W-1:0] w_push;
    logic [c_CNT_W-1:0] w_accept;
    logic               w_pop;
    logic               w_overflow;

    always_comb begin
        w_pop       = (r_count != '0) && i_ready;
        w_count_pop = r_count - c_CNT_W'(w_pop);
        w_free      = c_CNT_W'(DEPTH) - w_count_pop;
        w_push      = c_CNT_W'(i_push_cnt);
        w_overflow  = (w_push > w_free);
        w_accept    = w_overflow ? w_free : w_push;

        for (int i = 0; i < DEPTH; i++) begin
            w_data_nxt[i] = r_data[i];
        end
        for (int i = 0; i < DEPTH - 1; i++) begin
            if (w_pop) begin
                w_data_nxt[i] = r_data[i + 1];
            end
        end
        // New words land directly behind whatever survives the pop.
        for (int i = 0; i < DEPTH; i++) begin
            if ((w_accept != '0) && (c_CNT_W'(i) == w_count_pop)) begin
                w_data_nxt[i] = i_push_data0;
            end
            if ((w_accept == c_CNT_W'(2)) && (c_CNT_W'(i) == w_count_pop + c_CNT_W'(1))) begin
                w_data_nxt[i] = i_push_data1;
            end
        end
        w_count_nxt = w_count_pop + w_accept;

        if (i_flush) begin
            w_count_nxt = '0;
            w_overflow  = 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                w_data_nxt[i] = '0;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            r_count <= '0;
            r_err   <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                r_data[i] <= '0;
            end
        end else begin
            r_count <= w_count_nxt;
            r_err   <= w_overflow;
            for (int i = 0; i < DEPTH; i++) begin
                r_data[i] <= w_data_nxt[i];
            end
        end
    end

    assign o_data  = r_data[0];
    assign o_valid = (r_count != '0);
    assign o_err   = r_err;

endmodule
`default_nettype wire

// File: rtl/i2s_rx_deser.sv
`default_nettype none
// ============================================================================
//  Module      : i2s_rx_deser
//  Description : I2S receive channel. Samples one or two serial data lines
//                on the bit clock, aligns words to WS transitions, builds
//                words of cfg_wlen_i+1 bits and hands them to the RX FIFO
//                as right-aligned 32-bit entries.
//  Ports       : sck_i (bit clock), rstn_i (sync, active-low),
//                i2s_ch0_i / i2s_ch1_i / i2s_ws_i (serial inputs),
//                fifo_data_o / fifo_data_valid_o / fifo_data_ready_i,
//                fifo_err_o (overflow pulse), cfg_* (static while enabled).
//  Options     : I2S_RX_SIGN_EXT_EN - sign-extend completed words from bit
//                cfg_wlen_i; otherwise bits above the word are zero.
//  Revision    : 1.0 - initial release
// ============================================================================
module i2s_rx_deser
    import i2s_rx_pkg::*;
#(
    // Two entries so a ch0/ch1 pair completing together is held in full.
    parameter int OBUF_DEPTH = OBUF_DEPTH_DEF
) (
    input  logic        sck_i,
    input  logic        rstn_i,
    input  logic        i2s_ch0_i,
    input  logic        i2s_ch1_i,
    input  logic        i2s_ws_i,
    output logic [31:0] fifo_data_o,
    output logic        fifo_data_valid_o,
    input  logic        fifo_data_ready_i,
    output logic        fifo_err_o,
    input  logic        cfg_en_i,
    input  logic        cfg_2ch_i,
    input  logic [4:0]  cfg_wlen_i,
    input  logic [2:0]  cfg_wnum_i,
    input  logic        cfg_lsb_first_i
);

    state_t            r_state;
    state_t            w_state_nxt;
    logic              r_ws_q;
    logic [4:0]        r_bit_cnt;
    logic [3:0]        r_word_cnt;
    logic [WORD_W-1:0] r_sr0;
    logic [WORD_W-1:0] r_sr1;

    logic              w_ws_edge;
    logic              w_sample;
    logic              w_restart;
    logic              w_word_done;
    logic [WORD_W-1:0] w_sr0_nxt;
    logic [WORD_W-1:0] w_sr1_nxt;
    logic [WORD_W-1:0] w_word0;
    logic [WORD_W-1:0] w_word1;
    logic [1:0]        w_push_cnt;

    function automatic logic [WORD_W-1:0] finish_word(input logic [WORD_W-1:0] sr,
                                                      input logic [4:0]        wlen);
        logic [WORD_W-1:0] mask;
        mask = word_mask(wlen);
`ifdef I2S_RX_SIGN_EXT_EN
        return sr[wlen] ? (sr | ~mask) : (sr & mask);
`else
        return sr & mask;
`endif
    endfunction

    assign w_ws_edge = i2s_ws_i ^ r_ws_q;

    always_ff @(posedge sck_i) begin
        if (!rstn_i) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_sample    = 1'b0;
        w_restart   = 1'b0;
        w_word_done = 1'b0;
        if (!cfg_en_i) begin
            w_state_nxt = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    w_state_nxt = ST_WAIT_WS;
                end
                ST_WAIT_WS, ST_SKIP: begin
                    if (w_ws_edge) begin
                        w_state_nxt = ST_RUNNING;
                        w_restart   = 1'b1;
                    end
                end
                ST_RUNNING: begin
                    // A WS edge mid-slot realigns: the partial word is lost.
                    if (w_ws_edge) begin
                        w_restart = 1'b1;
                    end else begin
                        w_sample = 1'b1;
                        if (r_bit_cnt == cfg_wlen_i) begin
                            w_word_done = 1'b1;
                            if (r_word_cnt == {1'b0, cfg_wnum_i}) begin
                                w_state_nxt = ST_SKIP;
                            end
                        end
                    end
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                end
            endcase
        end
    end

    // The first bit of every word shifts into a cleared register.
    always_comb begin
        w_sr0_nxt  = shift_in((r_bit_cnt == 5'd0) ? '0 : r_sr0, i2s_ch0_i,
                              cfg_lsb_first_i, cfg_wlen_i);
        w_sr1_nxt  = shift_in((r_bit_cnt == 5'd0) ? '0 : r_sr1, i2s_ch1_i,
                              cfg_lsb_first_i, cfg_wlen_i);
        w_word0    = finish_word(w_sr0_nxt, cfg_wlen_i);
        w_word1    = finish_word(w_sr1_nxt, cfg_wlen_i);
        w_push_cnt = 2'd0;
        if (w_word_done) begin
            w_push_cnt = cfg_2ch_i ? 2'd2 : 2'd1;
        end
    end

    always_ff @(posedge sck_i) begin
        if (!rstn_i) begin
            r_ws_q     <= 1'b0;
            r_bit_cnt  <= '0;
            r_word_cnt <= '0;
            r_sr0      <= '0;
            r_sr1      <= '0;
        end else begin
            r_ws_q <= i2s_ws_i;
            if (!cfg_en_i || w_restart) begin
                r_bit_cnt  <= '0;
                r_word_cnt <= '0;
                r_sr0      <= '0;
                r_sr1      <= '0;
            end else if (w_sample) begin
                r_sr0 <= w_sr0_nxt;
                r_sr1 <= cfg_2ch_i ? w_sr1_nxt : '0;
                if (w_word_done) begin
                    r_bit_cnt  <= '0;
                    r_word_cnt <= r_word_cnt + 4'd1;
                end else begin
                    r_bit_cnt <= r_bit_cnt + 5'd1;
                end
            end
        end
    end

    i2s_rx_obuf #(
        .DEPTH (OBUF_DEPTH),
        .WIDTH (WORD_W)
    ) u_obuf (
        .i_clk        (sck_i),
        .i_rstn       (rstn_i),
        .i_flush      (!cfg_en_i),
        .i_push_cnt   (w_push_cnt),
        .i_push_data0 (w_word0),
        .i_push_data1 (w_word1),
        .o_data       (fifo_data_o),
        .o_valid      (fifo_data_valid_o),
        .i_ready      (fifo_data_ready_i),
        .o_err        (fifo_err_o)
    );

endmodule
`default_nettype wire
